// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial coefficient-memory controller.
package poly_pkg;
    localparam int unsigned N_COEFF = 512;
    localparam int unsigned COEFF_W = 16;
    localparam int unsigned N_SLOTS = 4;
    localparam int unsigned ADDR_W  = $clog2(N_COEFF);
    localparam int unsigned SLOT_W  = $clog2(N_SLOTS);

    typedef logic [SLOT_W-1:0]  slot_t;
    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        HOST_LOAD   = 2'b00,
        HOST_UNLOAD = 2'b01,
        HOST_CLEAR  = 2'b10,
        HOST_RSVD   = 2'b11
    } host_op_t;

    typedef enum logic [1:0] {
        IDLE,
        HLOAD,
        HUNLOAD,
        HCLEAR
    } state_t;

    function automatic logic is_last(input addr_t a);
        return a == addr_t'(N_COEFF - 1);
    endfunction
endpackage

// File: rtl/poly_ram_ctrl_if.sv
// Host streaming port: load stream (s_*) into the controller, unload stream (m_*) out of it.
interface poly_ram_ctrl_if;
    import poly_pkg::*;

    coeff_t s_data;
    logic   s_valid;
    logic   s_ready;
    coeff_t m_data;
    logic   m_valid;
    logic   m_ready;

    modport master (output s_data, s_valid, m_ready, input s_ready, m_data, m_valid);
    modport slave  (input s_data, s_valid, m_ready, output s_ready, m_data, m_valid);
endinterface

// File: rtl/poly_ram_slot.sv
// One polynomial slot: single write port, two registered read-first read ports.
module poly_ram_slot
    import poly_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   we,
    input  addr_t  waddr,
    input  coeff_t wdata,
    input  addr_t  raddr_a,
    input  addr_t  raddr_b,
    output coeff_t rdata_a,
    output coeff_t rdata_b
);
    coeff_t mem [N_COEFF];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
    end
endmodule

// File: rtl/poly_ram_ctrl.sv
// Polynomial slot storage with engine port and host load/unload/clear streaming.
// Optional host clear operation enabled by defining POLY_RAM_CLEAR_EN.
module poly_ram_ctrl
    import poly_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            eng_en,
    input  slot_t           eng_sel_a,
    input  slot_t           eng_sel_b,
    input  slot_t           eng_sel_d,
    input  addr_t           eng_addr,
    input  logic            eng_we,
    input  coeff_t          eng_din,
    output coeff_t          eng_doa,
    output coeff_t          eng_dob,
    input  logic            host_start,
    input  logic [1:0]      host_op,
    input  slot_t           host_slot,
    output logic            host_busy,
    output logic            host_done,
    output logic            host_err,
    poly_ram_ctrl_if.slave  bus
);
    state_t          state_q, state_d;
    addr_t           cnt_q, cnt_d;
    slot_t           slot_q, slot_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    slot_t           sel_a_q, sel_b_q;

    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            rd_vld_q;
    logic [1:0]      fcnt_q;
    coeff_t          fifo_q [2];

    logic            wr_en;
    slot_t           wr_slot;
    addr_t           wr_addr;
    coeff_t          wr_data;
    coeff_t          rdata_a [N_SLOTS];
    coeff_t          rdata_b [N_SLOTS];
    coeff_t          rd_word;
    logic            unload_act, s_ready_w, s_hs, m_valid_w, m_hs;
    logic            issue, push, pop, wr_idx;
    logic [1:0]      occ;

    assign host_busy  = (state_q != IDLE);
    assign host_done  = done_q;
    assign host_err   = err_q;
    assign unload_act = (state_q == HUNLOAD);
    assign s_ready_w  = (state_q == HLOAD);
    assign s_hs       = s_ready_w && bus.s_valid;

    // During unload the target slot's port A follows the read-ahead pointer, so
    // engine reads of that slot are not meaningful while the host owns it.
    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        localparam slot_t IDX = slot_t'(g);
        poly_ram_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .we      (wr_en && (wr_slot == IDX)),
            .waddr   (wr_addr),
            .wdata   (wr_data),
            .raddr_a ((unload_act && (slot_q == IDX)) ? rd_ptr_q[ADDR_W-1:0] : eng_addr),
            .raddr_b (eng_addr),
            .rdata_a (rdata_a[g]),
            .rdata_b (rdata_b[g])
        );
    end

    assign eng_doa = rdata_a[sel_a_q];
    assign eng_dob = rdata_b[sel_b_q];
    assign rd_word = rdata_a[slot_q];

    always_comb begin
        wr_en   = 1'b0;
        wr_slot = eng_sel_d;
        wr_addr = eng_addr;
        wr_data = eng_din;
        unique case (state_q)
            IDLE:  wr_en = eng_en && eng_we;
            HLOAD: begin
                wr_en   = s_hs;
                wr_slot = slot_q;
                wr_addr = cnt_q;
                wr_data = bus.s_data;
            end
`ifdef POLY_RAM_CLEAR_EN
            HCLEAR: begin
                wr_en   = 1'b1;
                wr_slot = slot_q;
                wr_addr = cnt_q;
                wr_data = '0;
            end
`endif
            default: wr_en = 1'b0;
        endcase
    end

    // Unload: the slot read register acts as a bypass stage ahead of a 2-entry
    // buffer; a read is only issued when the word is guaranteed a place to land.
    assign occ       = fcnt_q + {1'b0, rd_vld_q};
    assign issue     = unload_act && !rd_ptr_q[ADDR_W] && (occ <= 2'd1);
    assign m_valid_w = (fcnt_q != 2'd0) || rd_vld_q;
    assign m_hs      = m_valid_w && bus.m_ready;
    assign pop       = bus.m_ready && (fcnt_q != 2'd0);
    assign push      = rd_vld_q && !((fcnt_q == 2'd0) && bus.m_ready);
    assign wr_idx    = (fcnt_q != 2'd0) && !pop;

    assign bus.s_ready = s_ready_w;
    assign bus.m_valid = m_valid_w;
    assign bus.m_data  = (fcnt_q != 2'd0) ? fifo_q[0] : (rd_vld_q ? rd_word : '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        done_d   = 1'b0;
        err_d    = eng_we && host_busy;
        rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, issue};
        unique case (state_q)
            IDLE: begin
                rd_ptr_d = '0;
                if (host_start) begin
                    slot_d = host_slot;
                    cnt_d  = '0;
                    if (eng_en) begin
                        err_d = 1'b1;
                    end else begin
                        unique case (host_op_t'(host_op))
                            HOST_LOAD:   state_d = HLOAD;
                            HOST_UNLOAD: state_d = HUNLOAD;
`ifdef POLY_RAM_CLEAR_EN
                            HOST_CLEAR:  state_d = HCLEAR;
`endif
                            default:     err_d = 1'b1;
                        endcase
                    end
                end
            end
            HLOAD: begin
                if (s_hs) begin
                    cnt_d = cnt_q + addr_t'(1);
                    if (is_last(cnt_q)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            HUNLOAD: begin
                if (m_hs) begin
                    cnt_d = cnt_q + addr_t'(1);
                    if (is_last(cnt_q)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
`ifdef POLY_RAM_CLEAR_EN
            HCLEAR: begin
                cnt_d = cnt_q + addr_t'(1);
                if (is_last(cnt_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            slot_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            rd_ptr_q <= '0;
            rd_vld_q <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sel_a_q  <= eng_sel_a;
            sel_b_q  <= eng_sel_b;
            rd_ptr_q <= rd_ptr_d;
            rd_vld_q <= issue;
            fcnt_q   <= fcnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            fifo_q[0] <= fifo_q[1];
        end
        if (push) begin
            fifo_q[wr_idx] <= rd_word;
        end
    end
endmodule

// File: tb/tb_poly_ram_ctrl.sv
// Scoreboard bench for poly_ram_ctrl; covers the clear op when POLY_RAM_CLEAR_EN is defined.
module tb_poly_ram_ctrl;
    import poly_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       eng_en = 1'b0;
    slot_t      eng_sel_a = '0, eng_sel_b = '0, eng_sel_d = '0;
    addr_t      eng_addr = '0;
    logic       eng_we = 1'b0;
    coeff_t     eng_din = '0;
    coeff_t     eng_doa, eng_dob;
    logic       host_start = 1'b0;
    logic [1:0] host_op = 2'b00;
    slot_t      host_slot = '0;
    logic       host_busy, host_done, host_err;

    poly_ram_ctrl_if bus ();

    poly_ram_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .eng_en     (eng_en),
        .eng_sel_a  (eng_sel_a),
        .eng_sel_b  (eng_sel_b),
        .eng_sel_d  (eng_sel_d),
        .eng_addr   (eng_addr),
        .eng_we     (eng_we),
        .eng_din    (eng_din),
        .eng_doa    (eng_doa),
        .eng_dob    (eng_dob),
        .host_start (host_start),
        .host_op    (host_op),
        .host_slot  (host_slot),
        .host_busy  (host_busy),
        .host_done  (host_done),
        .host_err   (host_err),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: plain array of slot contents plus expected unload stream.
    coeff_t model [N_SLOTS][N_COEFF];
    coeff_t vals [N_COEFF];
    coeff_t exp_q [$];

    int n_checks = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int busy_cyc = 0;
    logic running = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic   hold = 1'b0;
        coeff_t hold_data = '0;
        while (running) begin
            @(negedge clk);
            if (!rst) begin
                if (host_done) done_cnt++;
                if (host_busy) busy_cyc++;
                if (hold) check("unload_stable", {bus.m_valid, bus.m_data}, {1'b1, hold_data});
                if (bus.m_valid && bus.m_ready) begin
                    check("unload_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("unload_data", bus.m_data, exp_q.pop_front());
                end
                hold = bus.m_valid && !bus.m_ready;
                hold_data = bus.m_data;
            end else begin
                hold = 1'b0;
            end
        end
    endtask

    task automatic watchdog();
        int w = 0;
        while (running && w < 300000) begin
            @(posedge clk);
            w++;
        end
        if (running) begin
            $display("FAIL watchdog: simulation exceeded cycle budget");
            $fatal(1, "watchdog expired");
        end
    endtask

    task automatic host_cmd(input logic [1:0] op, input slot_t slot);
        host_start = 1'b1;
        host_op    = op;
        host_slot  = slot;
        tick();
        host_start = 1'b0;
    endtask

    // mode 0: s_valid held, 1: toggling, 2: random
    task automatic feed(input slot_t slot, input int nwords, input int mode);
        int k = 0;
        int cyc = 0;
        logic acc;
        while (k < nwords && cyc < 4000) begin
            case (mode)
                0: bus.s_valid = 1'b1;
                1: bus.s_valid = (cyc % 2 == 0);
                default: bus.s_valid = 1'($urandom_range(0, 1));
            endcase
            bus.s_data = vals[k];
            @(negedge clk);
            acc = bus.s_valid && bus.s_ready;
            tick();
            if (acc) begin
                model[slot][k] = vals[k];
                k++;
            end
            cyc++;
        end
        bus.s_valid = 1'b0;
        check("load_words", k, nwords);
    endtask

    task automatic do_load(input slot_t slot, input int mode);
        int d0 = done_cnt;
        int b0 = busy_cyc;
        host_cmd(HOST_LOAD, slot);
        check("load_busy_rise", host_busy, 1);
        feed(slot, N_COEFF, mode);
        check("load_done_pulse", {host_done, host_busy}, 2'b10);
        tick();
        check("load_done_once", done_cnt - d0, 1);
        check("load_done_drop", host_done, 0);
        if (mode == 0) check("load_busy_cycles", busy_cyc - b0, 512);
    endtask

    // mode 0: m_ready held, 1: random
    task automatic do_unload(input slot_t slot, input int mode);
        int d0 = done_cnt;
        int b0 = busy_cyc;
        int cyc = 0;
        for (int unsigned i = 0; i < N_COEFF; i++) exp_q.push_back(model[slot][i]);
        bus.m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        host_cmd(HOST_UNLOAD, slot);
        @(negedge clk);
        check("unload_lat_c1", bus.m_valid, 0);
        tick();
        if (mode != 0) bus.m_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("unload_lat_c2", bus.m_valid, 1);
        tick();
        while (done_cnt == d0 && cyc < 6000) begin
            if (mode != 0) bus.m_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        bus.m_ready = 1'b0;
        check("unload_done_once", done_cnt - d0, 1);
        check("unload_all_words", exp_q.size(), 0);
        if (mode == 0) check("unload_busy_cycles", busy_cyc - b0, 513);
        exp_q.delete();
    endtask

    task automatic stimulus();
        coeff_t old;
        int d0, b0, cyc;
        slot_t a, b;
        addr_t ad;

        #12;
        check("rst_eng_doa", eng_doa, 0);
        check("rst_eng_dob", eng_dob, 0);
        check("rst_status", {host_busy, host_done, host_err}, 0);
        check("rst_stream", {bus.s_ready, bus.m_valid, bus.m_data}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        for (int unsigned i = 0; i < N_COEFF; i++) vals[i] = coeff_t'($urandom);
        vals[7] = 16'h0BAD;
        do_load(2'd0, 0);
        for (int unsigned i = 0; i < N_COEFF; i++) vals[i] = coeff_t'(i);
        do_load(2'd1, 1);
        for (int unsigned i = 0; i < N_COEFF; i++) vals[i] = coeff_t'(1000 + i);
        do_load(2'd2, 2);
        for (int unsigned i = 0; i < N_COEFF; i++) vals[i] = coeff_t'($urandom);
        do_load(2'd3, 0);

        do_unload(2'd1, 1);

        eng_en = 1'b1;
        eng_sel_a = 2'd1; eng_sel_b = 2'd2; eng_addr = 9'd5;
        tick();
        check("eng_rd_a5", eng_doa, 5);
        check("eng_rd_b5", eng_dob, 1005);
        for (int unsigned i = 0; i < 8; i++) begin
            a = slot_t'($urandom_range(0, 3));
            b = (i == 0) ? a : slot_t'($urandom_range(0, 3));
            ad = addr_t'($urandom_range(0, 511));
            eng_sel_a = a; eng_sel_b = b; eng_addr = ad;
            tick();
            check("eng_rd_a", eng_doa, model[a][ad]);
            check("eng_rd_b", eng_dob, model[b][ad]);
        end

        old = model[0][7];
        eng_we = 1'b1; eng_sel_d = 2'd0; eng_addr = 9'd7; eng_din = 16'h1234;
        eng_sel_a = 2'd0; eng_sel_b = 2'd0;
        tick();
        eng_we = 1'b0;
        check("eng_read_first", eng_doa, old);
        model[0][7] = 16'h1234;
        tick();
        check("eng_wr_a", eng_doa, 16'h1234);
        check("eng_wr_b", eng_dob, 16'h1234);
        eng_en = 1'b0;
        do_unload(2'd0, 0);

        eng_en = 1'b1;
        host_cmd(HOST_LOAD, 2'd1);
        check("err_eng_en", {host_err, host_busy}, 2'b10);
        tick();
        check("err_pulse_width", host_err, 0);
        eng_en = 1'b0;
        host_cmd(HOST_RSVD, 2'd1);
        check("err_reserved", {host_err, host_busy}, 2'b10);
        tick();

        for (int unsigned i = 0; i < N_COEFF; i++) vals[i] = coeff_t'(1000 + i);
        host_cmd(HOST_LOAD, 2'd2);
        eng_en = 1'b1; eng_we = 1'b1; eng_sel_d = 2'd3; eng_addr = 9'd10; eng_din = 16'hFFFF;
        tick();
        eng_we = 1'b0; eng_en = 1'b0;
        check("err_we_busy", {host_err, host_busy}, 2'b11);
        feed(2'd2, N_COEFF, 0);
        tick();
        do_unload(2'd3, 1);

        for (int unsigned i = 0; i < N_COEFF; i++) vals[i] = coeff_t'($urandom);
        d0 = done_cnt;
        host_cmd(HOST_LOAD, 2'd1);
        feed(2'd1, 100, 0);
        rst = 1'b1;
        #1;
        check("rstmid_status", {host_busy, host_done, host_err}, 0);
        check("rstmid_stream", {bus.s_ready, bus.m_valid, bus.m_data}, 0);
        check("rstmid_eng", {eng_doa, eng_dob}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("rstmid_no_done", done_cnt - d0, 0);
        do_unload(2'd1, 0);
        for (int unsigned i = 0; i < N_COEFF; i++) vals[i] = coeff_t'(i);
        do_load(2'd1, 1);
        do_unload(2'd1, 1);

`ifdef POLY_RAM_CLEAR_EN
        d0 = done_cnt;
        b0 = busy_cyc;
        cyc = 0;
        host_cmd(HOST_CLEAR, 2'd3);
        while (done_cnt == d0 && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("clear_done_once", done_cnt - d0, 1);
        check("clear_busy_cycles", busy_cyc - b0, 512);
        for (int unsigned i = 0; i < N_COEFF; i++) model[3][i] = '0;
        do_unload(2'd3, 0);
`else
        d0 = done_cnt;
        b0 = busy_cyc;
        cyc = 0;
        host_cmd(HOST_CLEAR, 2'd3);
        check("clear_rejected", {host_err, host_busy}, 2'b10);
        tick();
        check("clear_no_busy", busy_cyc - b0 + cyc, 0);
        check("clear_no_done", done_cnt - d0, 0);
`endif
        tick();
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        fork
            monitor();
            watchdog();
            begin
                stimulus();
                running = 1'b0;
            end
        join
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
